// File: rtl/aer_pkg.sv
// Shared definitions for the AER spike receive path: packet field positions
// and the receiver's time-step state machine encoding.
package aer_pkg;

    // Destination core field inside an AER packet
    localparam int unsigned AER_CORE_MSB = 31;
    localparam int unsigned AER_CORE_LSB = 24;
    localparam int unsigned AER_CORE_WIDTH = AER_CORE_MSB - AER_CORE_LSB + 1;

    // RUN: accepting packets; DRAIN: emptying the FIFO; SWAP: bank exchange
    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        SWAP  = 2'd2
    } rcvrState_t;

endpackage

// File: rtl/aer_sync_fifo.sv
// Single-clock FIFO with a registered head-of-queue output. Pointers carry one
// extra wrap bit so full and empty are told apart without a separate counter.
module aer_sync_fifo #(
    parameter int unsigned WIDTH     = 9,
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned PTR_WIDTH = 2
) (
    input  logic             clk,
    input  logic             rstN,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_WIDTH:0] wrPtr;
    logic [PTR_WIDTH:0] rdPtr;
    logic [PTR_WIDTH:0] rdPtrNext;
    logic               doPush;
    logic               doPop;

    assign empty  = (wrPtr == rdPtr);
    assign full   = (wrPtr[PTR_WIDTH] != rdPtr[PTR_WIDTH]) &&
                    (wrPtr[PTR_WIDTH-1:0] == rdPtr[PTR_WIDTH-1:0]);
    assign doPush = push && !full;
    assign doPop  = pop && !empty;
    assign rdPtrNext = rdPtr + {{PTR_WIDTH{1'b0}}, doPop};

    // Storage array; written only on an accepted push
    always_ff @(posedge clk) begin
        if (doPush) begin
            mem[wrPtr[PTR_WIDTH-1:0]] <= din;
        end
    end

    // Pointers and head register; the head is preloaded with whatever entry
    // will be at the front after this edge, bypassing din when that entry is
    // the one being written now.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            wrPtr <= '0;
            rdPtr <= '0;
            dout  <= '0;
        end else begin
            wrPtr <= wrPtr + {{PTR_WIDTH{1'b0}}, doPush};
            rdPtr <= rdPtrNext;
            if (rdPtrNext == wrPtr) begin
                dout <= din;
            end else begin
                dout <= mem[rdPtrNext[PTR_WIDTH-1:0]];
            end
        end
    end

endmodule

// File: rtl/aer_spike_rcvr.sv
// Receive side of the neuron spike interface. Buffers AER packets from the
// router, decodes them into per-axon spike bits for the current time step and,
// on each time-step tick, drains the buffer and swaps the double-buffered
// spike vector so the completed step is presented on inSpike_o.
module aer_spike_rcvr
    import aer_pkg::*;
#(
    parameter int unsigned NUM_AXONS          = 2,
    parameter int unsigned AXON_CNT_BIT_WIDTH = 1,
    parameter int unsigned AER_BIT_WIDTH      = 32,
    parameter logic [7:0]  CORE_ID            = 8'h00,
    parameter int unsigned FIFO_DEPTH         = 4,
    parameter int unsigned FIFO_PTR_WIDTH     = 2,
    parameter int unsigned DROP_CNT_WIDTH     = 8
) (
    input  logic                      clk_i,
    input  logic                      rst_n_i,
    input  logic                      start_i,
    input  logic [AER_BIT_WIDTH-1:0]  pkt_i,
    input  logic                      pktVld_i,
    output logic                      pktRdy_o,
    output logic [NUM_AXONS-1:0]      inSpike_o,
    output logic                      swapDone_o,
    output logic                      busy_o,
    output logic [DROP_CNT_WIDTH-1:0] dropCnt_o,
    output logic                      overrun_o
);

    // Only the core and axon fields travel through the FIFO
    localparam int unsigned ENTRY_WIDTH = AER_CORE_WIDTH + AXON_CNT_BIT_WIDTH;

    rcvrState_t state;

    logic [ENTRY_WIDTH-1:0]        fifoDin;
    logic [ENTRY_WIDTH-1:0]        fifoDout;
    logic                          fifoFull;
    logic                          fifoEmpty;
    logic                          fifoPush;
    logic                          fifoPop;
    logic [AER_CORE_WIDTH-1:0]     popCore;
    logic [AXON_CNT_BIT_WIDTH-1:0] popAxon;
    logic                          decodeHit;
    logic                          decodeMiss;
    logic [NUM_AXONS-1:0]          hitMask;
    logic [NUM_AXONS-1:0]          fillBank;
    logic [NUM_AXONS-1:0]          readBank;
    logic                          unusedPktBits;

    assign unusedPktBits = ^pkt_i[AER_CORE_LSB-1:AXON_CNT_BIT_WIDTH];

    assign pktRdy_o = !fifoFull && (state == RUN);
    assign fifoPush = pktVld_i && pktRdy_o;
    assign fifoPop  = !fifoEmpty && ((state == RUN) || (state == DRAIN));
    assign fifoDin  = {pkt_i[AER_CORE_MSB:AER_CORE_LSB], pkt_i[AXON_CNT_BIT_WIDTH-1:0]};

    assign popCore = fifoDout[ENTRY_WIDTH-1:AXON_CNT_BIT_WIDTH];
    assign popAxon = fifoDout[AXON_CNT_BIT_WIDTH-1:0];

    assign inSpike_o = readBank;

    aer_sync_fifo #(
        .WIDTH     (ENTRY_WIDTH),
        .DEPTH     (FIFO_DEPTH),
        .PTR_WIDTH (FIFO_PTR_WIDTH)
    ) uFifo (
        .clk   (clk_i),
        .rstN  (rst_n_i),
        .push  (fifoPush),
        .din   (fifoDin),
        .pop   (fifoPop),
        .full  (fifoFull),
        .empty (fifoEmpty),
        .dout  (fifoDout)
    );

    // Classify the entry popped this cycle and build its axon bit mask
    always_comb begin
        decodeHit  = 1'b0;
        decodeMiss = 1'b0;
        hitMask    = '0;
        if (fifoPop) begin
            if ((popCore == CORE_ID) && (32'(popAxon) < NUM_AXONS)) begin
                decodeHit = 1'b1;
                hitMask   = NUM_AXONS'(1) << popAxon;
            end else begin
                decodeMiss = 1'b1;
            end
        end
    end

    // Accumulate decoded spikes into the fill bank; hand it over on SWAP
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            fillBank <= '0;
            readBank <= '0;
        end else if (state == SWAP) begin
            readBank <= fillBank | hitMask;
            fillBank <= '0;
        end else if (decodeHit) begin
            fillBank <= fillBank | hitMask;
        end
    end

    // Saturating count of discarded packets
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            dropCnt_o <= '0;
        end else if (decodeMiss && (dropCnt_o != '1)) begin
            dropCnt_o <= dropCnt_o + 1'b1;
        end
    end

    // Time-step state machine with registered busy, swap and overrun flags
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state      <= RUN;
            busy_o     <= 1'b0;
            swapDone_o <= 1'b0;
            overrun_o  <= 1'b0;
        end else begin
            swapDone_o <= 1'b0;
            case (state)
                RUN: begin
                    if (start_i) begin
                        state  <= DRAIN;
                        busy_o <= 1'b1;
                    end
                end
                DRAIN: begin
                    if (start_i) begin
                        overrun_o <= 1'b1;
                    end
                    if (fifoEmpty) begin
                        state <= SWAP;
                    end
                end
                SWAP: begin
                    if (start_i) begin
                        overrun_o <= 1'b1;
                    end
                    state      <= RUN;
                    busy_o     <= 1'b0;
                    swapDone_o <= 1'b1;
                end
                default: begin
                    state  <= RUN;
                    busy_o <= 1'b0;
                end
            endcase
        end
    end

endmodule
